fb_plot_sink: RTL and testbench
===============================

# fb_plot_sink

Receiving end of the pixel plot interface driven by the object drawers (x, y, colour, plot). Buffers plot strobes in a small FIFO, drains them into an internal single-port 160x120 3-bit frame memory, and provides a read port that Connect4 game logic uses to sample pixel colours, e.g. for collision and occupancy checks. Also performs a full-screen clear on request. Sits between the drawing engines and game logic, alongside the VGA adapter.

## Interface
- XW, 8, x coordinate width
- YW, 7, y coordinate width
- CW, 3, colour width
- WIDTH, 160, pixels per row
- HEIGHT, 120, rows
- FIFO_DEPTH, 4, plot FIFO entries (power of 2)
- clock  in  1  system clock (CLOCK_50); all state changes on its rising edge
- resetn  in  1  asynchronous, active-low reset
- x  in  XW  plot column
- y  in  YW  plot row
- colour  in  CW  plot colour
- plot  in  1  plot request; accepted on an edge where plot && plot_ready
- plot_ready  out  1  FIFO can accept
- rd_req  in  1  read request; hold until rd_ack
- rd_x  in  XW  read column
- rd_y  in  YW  read row
- rd_ack  out  1  one-cycle pulse: read granted this edge
- rd_valid  out  1  one-cycle pulse, cycle after rd_ack
- rd_colour  out  CW  read data, valid with rd_valid, held until the next read
- clear  in  1  start a full-screen clear, sampled in IDLE only
- clear_colour  in  CW  fill colour, captured on clear acceptance
- clear_done  out  1  one-cycle pulse when the clear completes
- fifo_empty  out  1  no pending plots
- drop_count  out  8  count of out-of-range plots, saturating at 255

## Operation
- Address = y*WIDTH + x, 15 bits, computed as (y<<7)+(y<<5)+x for WIDTH=160.
- Out-of-range plot (x>=WIDTH or y>=HEIGHT): accepted (handshake completes) but not enqueued; drop_count increments and saturates.
- States: IDLE, DRAIN, CLEAR.
- IDLE: one memory operation per cycle, with this priority:
  - FIFO full: pop and write.
  - Else rd_req: read, rd_ack=1.
  - Else FIFO non-empty: pop and write.
- clear in IDLE: capture clear_colour, go to DRAIN.
- DRAIN: plot_ready=0, reads not acked, FIFO pops one per cycle. When FIFO empty, go to CLEAR with sweep address 0.
- CLEAR: write clear_colour at the sweep address and increment it. After the write to address 19199, pulse clear_done and return to IDLE. Total time in CLEAR is 19200 cycles.
- clear asserted in DRAIN or CLEAR is ignored.
- Out-of-range read: still acked; rd_valid returns rd_colour=0; memory is not accessed.
- Coherency: reads return memory contents only; plots still in the FIFO are not forwarded. Callers wait for fifo_empty when they need ordering.
- plot_ready = (state==IDLE) && !full.
- A push and a pop on the same edge leave the occupancy unchanged.

## Timing
- Reset values:
  - plot_ready=1, fifo_empty=1, FIFO pointers 0.
  - state IDLE, rd_ack=0, rd_valid=0, rd_colour=0, clear_done=0, drop_count=0.
  - Memory contents are not reset; issue clear after reset.
- Plot latency: plot accepted at edge N into an empty FIFO with no rd_req → memory written at edge N+1.
- Read latency: rd_ack asserted combinationally in the grant cycle; the request is registered at edge N; rd_valid and rd_colour appear after edge N+1.
- Sustained plotting at one per cycle with no reads never deasserts plot_ready.
- A continuous rd_req stream fills the FIFO. Once full, writes take priority; reads are guaranteed at least every other cycle.
- Reset asserted mid-DRAIN or mid-CLEAR: return immediately to IDLE, empty the FIFO, no clear_done.

## Test plan
- Reset, clear with clear_colour=3'b001, wait for clear_done → exactly 19200 cycles spent in CLEAR; read (0,0) and (159,119) → rd_colour=3'b001.
- Plot (10,20,3'b100); wait for fifo_empty; read (10,20) → rd_valid one cycle after rd_ack, rd_colour=3'b100; neighbouring pixel (11,20) still 3'b001.
- Plot 8 pixels back-to-back while holding rd_req → plot_ready drops when the FIFO holds 4; all 8 pixels eventually land; reads and writes interleave after the FIFO fills.
- Plot (160,5) and (5,120) → drop_count=2 and memory unchanged; read (200,0) → rd_colour=0.
- Assert clear with 3 plots pending → the 3 plots are written first (DRAIN), then the fill overwrites them; a clear pulse during CLEAR is ignored.
- Assert resetn low midway through CLEAR → all outputs return to reset values; clear_done never pulses.

Source files
------------

// File: rtl/fb_plot_sink.sv
// Pixel plot sink. Plots are queued in a small FIFO and drained into a 160x120 frame
// memory that also serves granted reads and a full-screen clear sweep.
module fb_plot_sink #(
    parameter int XW         = 8,
    parameter int YW         = 7,
    parameter int CW         = 3,
    parameter int WIDTH      = 160,
    parameter int HEIGHT     = 120,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  logic [CW-1:0] colour,
    input  logic          plot,
    output logic          plot_ready,
    input  logic          rd_req,
    input  logic [XW-1:0] rd_x,
    input  logic [YW-1:0] rd_y,
    output logic          rd_ack,
    output logic          rd_valid,
    output logic [CW-1:0] rd_colour,
    input  logic          clear,
    input  logic [CW-1:0] clear_colour,
    output logic          clear_done,
    output logic          fifo_empty,
    output logic [7:0]    drop_count
);
    localparam int NPIX = WIDTH * HEIGHT;
    localparam int AW   = $clog2(NPIX);
    localparam int FPW  = $clog2(FIFO_DEPTH);
    localparam logic [FPW:0] PTR_ONE = (FPW + 1)'(1);

    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_e;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [CW-1:0] colour;
    } plot_t;

    // y*160 + x built from shifts so no multiplier is needed.
    function automatic logic [AW-1:0] pix_addr(input logic [XW-1:0] px, input logic [YW-1:0] py);
        return (AW'(py) << 7) + (AW'(py) << 5) + AW'(px);
    endfunction

    state_e        state_q;
    logic [AW-1:0] sweep_q;
    logic [CW-1:0] clear_colour_q;
    logic          clear_done_q;
    logic [FPW:0]  wr_ptr_q, rd_ptr_q;
    logic [7:0]    drop_q;
    logic          rd_pend_q, rd_in_range_q, rd_valid_q;
    logic [CW-1:0] rd_colour_q, mem_rdata_q;

    plot_t         fifo_mem [FIFO_DEPTH];
    logic [CW-1:0] frame_mem [NPIX];

    logic          full, empty, plot_in_range, rd_in_range, push, pop, rd_grant;
    logic          mem_we, mem_re;
    logic [AW-1:0] mem_addr;
    logic [CW-1:0] mem_wdata;
    plot_t         head;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[FPW] != rd_ptr_q[FPW]) && (wr_ptr_q[FPW-1:0] == rd_ptr_q[FPW-1:0]);
    assign head  = fifo_mem[rd_ptr_q[FPW-1:0]];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        plot_in_range = (x < XW'(WIDTH)) && (y < YW'(HEIGHT));
        rd_in_range   = (rd_x < XW'(WIDTH)) && (rd_y < YW'(HEIGHT));
        push          = plot && plot_ready && plot_in_range;
        rd_grant      = (state_q == IDLE) && rd_req && !full;
        pop           = !empty && (((state_q == IDLE) && (full || !rd_req)) || (state_q == DRAIN));
        mem_we        = pop || (state_q == CLEAR);
        mem_re        = rd_grant && rd_in_range;
        mem_addr      = head.addr;
        mem_wdata     = head.colour;
        if (state_q == CLEAR) begin
            mem_addr  = sweep_q;
            mem_wdata = clear_colour_q;
        end else if (rd_grant) begin
            mem_addr  = pix_addr(rd_x, rd_y);
        end
    end

    assign plot_ready = (state_q == IDLE) && !full;
    assign rd_ack     = rd_grant;
    assign rd_valid   = rd_valid_q;
    assign rd_colour  = rd_colour_q;
    assign clear_done = clear_done_q;
    assign fifo_empty = empty;
    assign drop_count = drop_q;

    // NOTE: storage arrays carry no reset; their contents are qualified by pointers or a clear.
    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr_q[FPW-1:0]] <= '{addr: pix_addr(x, y), colour: colour};
    end

    // Single-port frame memory: exactly one write or one read per cycle.
    always_ff @(posedge clock) begin
        if (mem_we)      frame_mem[mem_addr] <= mem_wdata;
        else if (mem_re) mem_rdata_q <= frame_mem[mem_addr];
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            drop_q        <= '0;
            rd_pend_q     <= 1'b0;
            rd_in_range_q <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_colour_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (plot && plot_ready && !plot_in_range && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
            rd_pend_q     <= rd_grant;
            rd_in_range_q <= rd_in_range;
            rd_valid_q    <= rd_pend_q;
            if (rd_pend_q) rd_colour_q <= rd_in_range_q ? mem_rdata_q : '0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q        <= IDLE;
            sweep_q        <= '0;
            clear_colour_q <= '0;
            clear_done_q   <= 1'b0;
        end else begin
            clear_done_q <= 1'b0;
            unique case (state_q)
                IDLE: if (clear) begin
                    clear_colour_q <= clear_colour;
                    state_q        <= DRAIN;
                end
                DRAIN: if (empty) begin
                    sweep_q <= '0;
                    state_q <= CLEAR;
                end
                CLEAR: begin
                    sweep_q <= sweep_q + AW'(1);
                    if (sweep_q == AW'(NPIX - 1)) begin
                        clear_done_q <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fb_plot_sink.sv
// Directed bench for fb_plot_sink: clear timing, plot/read latency, FIFO backpressure,
// out-of-range handling, clear with pending plots and reset during a clear.
module tb_fb_plot_sink;
    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] x = '0;
    logic [6:0] y = '0;
    logic [2:0] colour = '0;
    logic       plot = 1'b0;
    logic       plot_ready;
    logic       rd_req = 1'b0;
    logic [7:0] rd_x = '0;
    logic [6:0] rd_y = '0;
    logic       rd_ack, rd_valid;
    logic [2:0] rd_colour;
    logic       clear = 1'b0;
    logic [2:0] clear_colour = '0;
    logic       clear_done, fifo_empty;
    logic [7:0] drop_count;

    int n_cmp = 0;
    int n_bad = 0;

    fb_plot_sink dut (
        .clock(clock), .resetn(resetn), .x(x), .y(y), .colour(colour), .plot(plot),
        .plot_ready(plot_ready), .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y),
        .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_colour(rd_colour), .clear(clear),
        .clear_colour(clear_colour), .clear_done(clear_done), .fifo_empty(fifo_empty),
        .drop_count(drop_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic do_plot(input int px, input int py, input logic [2:0] c);
        int n = 0;
        @(negedge clock);
        plot = 1'b1; x = px[7:0]; y = py[6:0]; colour = c;
        #1;
        while (!plot_ready && n < 100) begin
            @(negedge clock); #1; n++;
        end
        @(negedge clock);
        plot = 1'b0;
    endtask

    task automatic do_read(input int rx, input int ry, output logic [2:0] col);
        int n = 0;
        @(negedge clock);
        rd_req = 1'b1; rd_x = rx[7:0]; rd_y = ry[6:0];
        #1;
        while (!rd_ack && n < 100) begin
            @(negedge clock); #1; n++;
        end
        check("rd_ack_seen", 32'(rd_ack), 1);
        @(negedge clock);
        rd_req = 1'b0;
        check("rd_valid_not_yet", 32'(rd_valid), 0);
        @(negedge clock);
        check("rd_valid_pulse", 32'(rd_valid), 1);
        col = rd_colour;
    endtask

    task automatic wait_empty();
        int n = 0;
        while (!fifo_empty && n < 200) begin
            @(negedge clock); n++;
        end
        check("fifo_drained", 32'(fifo_empty), 1);
    endtask

    initial begin
        logic [2:0] col;
        int cnt, acc, acks_after_full;
        bit seen_full, seen_done;

        // Reset values
        #1;
        check("rst_plot_ready", 32'(plot_ready), 1);
        check("rst_fifo_empty", 32'(fifo_empty), 1);
        check("rst_rd_valid",   32'(rd_valid), 0);
        check("rst_rd_colour",  32'(rd_colour), 0);
        check("rst_clear_done", 32'(clear_done), 0);
        check("rst_drop_count", 32'(drop_count), 0);
        @(negedge clock); @(negedge clock);
        resetn = 1'b1;

        // Clear to 3'b001: 1 DRAIN cycle + 19200 CLEAR cycles after the accepting edge
        @(negedge clock);
        clear = 1'b1; clear_colour = 3'b001;
        cnt = 0;
        do begin
            @(negedge clock);
            clear = 1'b0; cnt++;
            if (cnt == 1) check("clear_blocks_plot", 32'(plot_ready), 0);
        end while (!clear_done && cnt < 20000);
        check("clear1_cycles", 32'(cnt), 19202);
        @(negedge clock);
        check("clear_done_one_cycle", 32'(clear_done), 0);
        check("idle_after_clear", 32'(plot_ready), 1);
        do_read(0, 0, col);     check("px_0_0", 32'(col), 1);
        do_read(159, 119, col); check("px_159_119", 32'(col), 1);

        // Single plot latency and readback
        do_plot(10, 20, 3'b100);
        check("plot_queued", 32'(fifo_empty), 0);
        @(negedge clock);
        check("plot_written_next", 32'(fifo_empty), 1);
        do_read(10, 20, col); check("px_10_20", 32'(col), 3'b100);
        do_read(11, 20, col); check("px_11_20", 32'(col), 1);

        // 8 back-to-back plots under a continuous read stream
        @(negedge clock);
        rd_req = 1'b1; rd_x = 8'd0; rd_y = 7'd0;
        acc = 0; acks_after_full = 0; seen_full = 1'b0;
        for (int cyc = 0; cyc < 100 && acc < 8; cyc++) begin
            if (cyc > 0) @(negedge clock);
            plot = 1'b1; x = 8'(30 + acc); y = 7'd50; colour = 3'(acc) ^ 3'b110;
            #1;
            if (!plot_ready && !seen_full) begin
                seen_full = 1'b1;
                check("full_at_4", 32'(acc), 4);
            end
            if (seen_full && rd_ack) acks_after_full++;
            if (plot_ready) acc++;
        end
        @(negedge clock);
        plot = 1'b0; rd_req = 1'b0;
        check("burst_all_accepted", 32'(acc), 8);
        check("reads_interleave", 32'(acks_after_full > 0), 1);
        wait_empty();
        for (int i = 0; i < 8; i++) begin
            do_read(30 + i, 50, col);
            check("burst_px", 32'(col), 32'(3'(i) ^ 3'b110));
        end

        // Out-of-range plots and read
        do_plot(160, 5, 3'b111);
        check("oor_not_queued", 32'(fifo_empty), 1);
        do_plot(5, 120, 3'b111);
        check("drop_count_2", 32'(drop_count), 2);
        do_read(0, 6, col);   check("alias_px_unchanged", 32'(col), 1);
        do_read(200, 0, col); check("oor_read_zero", 32'(col), 0);

        // Clear with 3 plots pending; a clear pulse during CLEAR is ignored
        @(negedge clock);
        rd_req = 1'b1; rd_x = 8'd0; rd_y = 7'd0;
        do_plot(40, 60, 3'b111);
        do_plot(41, 60, 3'b110);
        do_plot(42, 60, 3'b101);
        check("three_pending", 32'(fifo_empty), 0);
        rd_req = 1'b0; clear = 1'b1; clear_colour = 3'b010;
        cnt = 0;
        do begin
            @(negedge clock);
            clear = 1'b0; cnt++;
            if (cnt == 2) check("drain_in_progress", 32'(fifo_empty), 0);
            if (cnt == 3) check("drain_finished", 32'(fifo_empty), 1);
            if (cnt == 100) begin clear = 1'b1; clear_colour = 3'b111; end
        end while (!clear_done && cnt < 20000);
        check("clear2_cycles", 32'(cnt), 19204);
        @(negedge clock);
        check("no_restart", 32'(plot_ready), 1);
        for (int i = 0; i < 3; i++) begin
            do_read(40 + i, 60, col);
            check("overwritten_px", 32'(col), 3'b010);
        end

        // Reset in the middle of CLEAR
        @(negedge clock);
        clear = 1'b1; clear_colour = 3'b101;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clock);
            clear = 1'b0;
        end
        check("mid_clear_busy", 32'(plot_ready), 0);
        resetn = 1'b0;
        #1;
        check("mr_plot_ready", 32'(plot_ready), 1);
        check("mr_fifo_empty", 32'(fifo_empty), 1);
        check("mr_rd_valid",   32'(rd_valid), 0);
        check("mr_rd_colour",  32'(rd_colour), 0);
        check("mr_clear_done", 32'(clear_done), 0);
        check("mr_drop_count", 32'(drop_count), 0);
        @(negedge clock);
        resetn = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clock);
            if (clear_done) seen_done = 1'b1;
        end
        check("no_clear_done_after_reset", 32'(seen_done), 0);
        check("idle_after_reset", 32'(plot_ready), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
